// File: rtl/aes_round_sequencer.sv
// AES round sequencer: arbitrates encrypt/decrypt jobs and walks the round/key schedule.
// Optional macro AES_SEQ_RR_ARB_EN: round-robin tie-break instead of fixed encrypt priority.
module aes_round_sequencer #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = NK + 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_req,
  input  logic       dec_req,
  output logic       enc_ack,
  output logic       dec_ack,
  output logic       mode,
  output logic       load,
  output logic [3:0] round_idx,
  output logic [3:0] key_sel,
  output logic       last_round,
  output logic       done,
  output logic       done_mode,
  output logic       busy,
  output logic [7:0] jobs_done
);

  localparam logic [3:0] NrW = 4'(NR);

  typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_t;

  state_t     state;
  logic       any_req;
  logic       grant_dec;
  logic       tie_dec;
  logic [3:0] next_r;

`ifdef AES_SEQ_RR_ARB_EN
  logic last_dec;
  // A tie goes to whichever mode was not granted most recently.
  assign tie_dec = ~last_dec;
`else
  assign tie_dec = 1'b0;
`endif

  always_comb begin
    any_req   = enc_req | dec_req;
    grant_dec = dec_req & (~enc_req | tie_dec);
    next_r    = round_idx + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      enc_ack    <= 1'b0;
      dec_ack    <= 1'b0;
      mode       <= 1'b0;
      load       <= 1'b0;
      round_idx  <= 4'd0;
      key_sel    <= 4'd0;
      last_round <= 1'b0;
      done       <= 1'b0;
      done_mode  <= 1'b0;
      busy       <= 1'b0;
      jobs_done  <= 8'd0;
`ifdef AES_SEQ_RR_ARB_EN
      last_dec   <= 1'b1;
`endif
    end else begin
      enc_ack    <= 1'b0;
      dec_ack    <= 1'b0;
      load       <= 1'b0;
      last_round <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (any_req) begin
            state     <= StInit;
            mode      <= grant_dec;
            enc_ack   <= ~grant_dec;
            dec_ack   <= grant_dec;
            load      <= 1'b1;
            round_idx <= 4'd0;
            key_sel   <= grant_dec ? NrW : 4'd0;
            busy      <= 1'b1;
`ifdef AES_SEQ_RR_ARB_EN
            last_dec  <= grant_dec;
`endif
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        StInit, StRound: begin
          round_idx <= next_r;
          if (next_r == NrW) begin
            state      <= StFinal;
            last_round <= 1'b1;
            key_sel    <= mode ? 4'd0 : NrW;
          end else begin
            state   <= StRound;
            key_sel <= mode ? (NrW - next_r) : next_r;
          end
        end
        StFinal: begin
          state     <= StDone;
          done      <= 1'b1;
          done_mode <= mode;
          jobs_done <= jobs_done + 8'd1;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer (NR = 10).
module tb_aes_round_sequencer;

  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_req;
  logic       dec_req;
  logic       enc_ack;
  logic       dec_ack;
  logic       mode;
  logic       load;
  logic [3:0] round_idx;
  logic [3:0] key_sel;
  logic       last_round;
  logic       done;
  logic       done_mode;
  logic       busy;
  logic [7:0] jobs_done;

  int checks = 0;
  int failures = 0;

  aes_round_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .enc_req   (enc_req),
    .dec_req   (dec_req),
    .enc_ack   (enc_ack),
    .dec_ack   (dec_ack),
    .mode      (mode),
    .load      (load),
    .round_idx (round_idx),
    .key_sel   (key_sel),
    .last_round(last_round),
    .done      (done),
    .done_mode (done_mode),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the INIT cycle that has just been entered.
  task automatic check_init(input logic dec);
    check("init_enc_ack", {31'd0, enc_ack}, {31'd0, ~dec});
    check("init_dec_ack", {31'd0, dec_ack}, {31'd0, dec});
    check("init_mode", {31'd0, mode}, {31'd0, dec});
    check("init_load", {31'd0, load}, 32'd1);
    check("init_round", {28'd0, round_idx}, 32'd0);
    check("init_key", {28'd0, key_sel}, dec ? NR : 0);
    check("init_busy", {31'd0, busy}, 32'd1);
  endtask

  // Walks rounds first_r..NR-1, FINAL and DONE, checking each cycle.
  task automatic run_job(input logic dec, input int first_r, input logic [7:0] jobs_exp);
    for (int r = first_r; r < NR; r++) begin
      step();
      check("round_idx", {28'd0, round_idx}, r);
      check("round_key", {28'd0, key_sel}, dec ? NR - r : r);
      check("round_flags", {27'd0, load, last_round, enc_ack, dec_ack, done}, 32'd0);
    end
    step();
    check("final_idx", {28'd0, round_idx}, NR);
    check("final_key", {28'd0, key_sel}, dec ? 0 : NR);
    check("final_last", {31'd0, last_round}, 32'd1);
    check("final_done", {31'd0, done}, 32'd0);
    step();
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_mode", {31'd0, done_mode}, {31'd0, dec});
    check("done_count", {24'd0, jobs_done}, {24'd0, jobs_exp});
    check("done_last", {31'd0, last_round}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int idle_seen;
    int done_seen;
    reset   = 1'b1;
    enc_req = 1'b0;
    dec_req = 1'b0;
    do_reset();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {26'd0, enc_ack, dec_ack, load, last_round, done, done_mode}, 32'd0);
    check("rst_round", {28'd0, round_idx}, 32'd0);
    check("rst_key", {28'd0, key_sel}, 32'd0);
    check("rst_jobs", {24'd0, jobs_done}, 32'd0);

    // Single encrypt job.
    enc_req = 1'b1;
    step();
    enc_req = 1'b0;
    check_init(1'b0);
    run_job(1'b0, 1, 8'd1);
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_hold_idx", {28'd0, round_idx}, NR);
    check("idle_hold_key", {28'd0, key_sel}, NR);

    // Single decrypt job.
    dec_req = 1'b1;
    step();
    dec_req = 1'b0;
    check_init(1'b1);
    run_job(1'b1, 1, 8'd2);
    step();
    check("idle2_busy", {31'd0, busy}, 32'd0);

    // Reset mid-job aborts without a done pulse.
    enc_req = 1'b1;
    step();
    enc_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort_at_r5", {28'd0, round_idx}, 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_round", {28'd0, round_idx}, 32'd0);
    check("abort_jobs", {24'd0, jobs_done}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) done_seen++;
    end
    check("abort_quiet", done_seen, 32'd0);

    // Decrypt request arriving mid-encrypt waits for DONE, then goes straight to INIT.
    enc_req = 1'b1;
    step();
    enc_req = 1'b0;
    check_init(1'b0);
    step();
    check("mid_r1", {28'd0, round_idx}, 32'd1);
    dec_req = 1'b1;
    run_job(1'b0, 2, 8'd1);
    step();
    dec_req = 1'b0;
    check_init(1'b1);
    run_job(1'b1, 1, 8'd2);

    // Both requests held from reset.
    enc_req = 1'b0;
    dec_req = 1'b0;
    do_reset();
    enc_req = 1'b1;
    dec_req = 1'b1;
    step();
    check_init(1'b0);
    run_job(1'b0, 1, 8'd1);
    step();
`ifdef AES_SEQ_RR_ARB_EN
    check_init(1'b1);
    run_job(1'b1, 1, 8'd2);
`else
    check_init(1'b0);
    run_job(1'b0, 1, 8'd2);
`endif
    step();
    check_init(1'b0);
    run_job(1'b0, 1, 8'd3);
    enc_req = 1'b0;
    dec_req = 1'b0;

    // 256 back-to-back encrypt jobs; the count wraps to zero.
    do_reset();
    enc_req = 1'b1;
    idle_seen = 0;
    done_seen = 0;
    for (int j = 0; j < 256; j++) begin
      for (int c = 1; c <= NR + 2; c++) begin
        step();
        if (!busy) idle_seen++;
        if (done) done_seen++;
        if (c == NR + 2) begin
          check("b2b_done", {31'd0, done}, 32'd1);
          check("b2b_count", {24'd0, jobs_done}, (j + 1) % 256);
        end
      end
    end
    enc_req = 1'b0;
    check("b2b_no_idle", idle_seen, 32'd0);
    check("b2b_dones", done_seen, 32'd256);
    check("b2b_wrap", {24'd0, jobs_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
